// File: rtl/bp_me_wormhole_pkg.sv
// Shared definitions for the wormhole LCE command path: scheduler states and
// the packet-length helper used by the encoders that feed the scheduler.
package bp_me_wormhole_pkg;

  typedef enum logic {
    e_sched_idle,
    e_sched_send
  } sched_state_e;

  function automatic int cdiv(input int bits, input int flit_width);
    return (bits + flit_width - 1) / flit_width;
  endfunction

  // Wormhole len field value for a payload of the given size: flits minus one.
  function automatic int flit_len(input int bits, input int flit_width);
    return cdiv(bits, flit_width) - 1;
  endfunction

endpackage

// File: rtl/bp_me_rr_arbiter.sv
// Combinational round-robin picker: searches upward from rr_ptr_i with wrap and
// returns the first valid requester as a one-hot grant and as an index.
module bp_me_rr_arbiter #(
  parameter int num_req_p  = 2,
  parameter int id_width_p = 1
) (
  input  logic [num_req_p-1:0]  req_i,
  input  logic [id_width_p-1:0] rr_ptr_i,
  output logic [num_req_p-1:0]  grant_o,
  output logic [id_width_p-1:0] grant_id_o,
  output logic                  v_o
);

  // Outer loop walks priority order; the first hit blocks all later ones.
  always_comb begin
    grant_o    = '0;
    grant_id_o = '0;
    v_o        = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      for (int j = 0; j < num_req_p; j++) begin
        if (!v_o && req_i[j] && (j == ((int'(rr_ptr_i) + i) % num_req_p))) begin
          v_o        = 1'b1;
          grant_o[j] = 1'b1;
          grant_id_o = id_width_p'(j);
        end
      end
    end
  end

endmodule

// File: rtl/bp_me_wormhole_lce_cmd_flit_scheduler.sv
// Round-robin scheduler that buffers one whole wormhole LCE command packet and
// serializes it flit by flit onto the coh NoC injection link.
module bp_me_wormhole_lce_cmd_flit_scheduler
  import bp_me_wormhole_pkg::*;
#(
  parameter int num_req_p    = 2,
  parameter int flit_width_p = 64,
  parameter int len_width_p  = 4,
  parameter int max_flits_p  = 16,
  parameter int pkt_width_p  = flit_width_p * max_flits_p,
  localparam int id_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p-1:0]             req_v_i,
  input  logic [num_req_p*pkt_width_p-1:0] req_pkt_i,
  input  logic [num_req_p*len_width_p-1:0] req_len_i,
  output logic [num_req_p-1:0]             req_yumi_o,
  output logic [flit_width_p-1:0]          link_data_o,
  output logic                             link_v_o,
  input  logic                             link_ready_and_i,
  output logic                             busy_o,
  output logic [id_width_lp-1:0]           grant_id_o
);

  sched_state_e             state_r, state_n;
  logic [len_width_p-1:0]   cnt_r, cnt_n, len_r, len_n;
  logic [pkt_width_p-1:0]   buf_r, buf_n;
  logic [id_width_lp-1:0]   grant_id_r, grant_id_n, rr_ptr_r, rr_ptr_n;

  logic [num_req_p-1:0]     arb_grant;
  logic [id_width_lp-1:0]   arb_id;
  logic                     arb_v;
  logic [pkt_width_p-1:0]   win_pkt;
  logic [len_width_p-1:0]   win_len;
  logic                     send, last_hs, load;

  bp_me_rr_arbiter #(
    .num_req_p  (num_req_p),
    .id_width_p (id_width_lp)
  ) arb (
    .req_i      (req_v_i),
    .rr_ptr_i   (rr_ptr_r),
    .grant_o    (arb_grant),
    .grant_id_o (arb_id),
    .v_o        (arb_v)
  );

  assign win_pkt = req_pkt_i[int'(arb_id)*pkt_width_p +: pkt_width_p];
  assign win_len = req_len_i[int'(arb_id)*len_width_p +: len_width_p];

  assign send    = (state_r == e_sched_send);
  assign last_hs = send && link_ready_and_i && (cnt_r == len_r);
  assign load    = (state_r == e_sched_idle) || last_hs;

  // Yumi is gated by reset so the consume pulse dies as soon as reset asserts.
  assign req_yumi_o  = (load && reset_n_i) ? arb_grant : '0;
  assign link_v_o    = send;
  assign busy_o      = send;
  assign grant_id_o  = grant_id_r;
  assign link_data_o = send ? buf_r[int'(cnt_r)*flit_width_p +: flit_width_p] : '0;

  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    len_n      = len_r;
    buf_n      = buf_r;
    grant_id_n = grant_id_r;
    rr_ptr_n   = rr_ptr_r;
    if (load) begin
      if (arb_v) begin
        state_n    = e_sched_send;
        cnt_n      = '0;
        len_n      = win_len;
        buf_n      = win_pkt;
        grant_id_n = arb_id;
        rr_ptr_n   = (int'(arb_id) == num_req_p - 1) ? '0 : arb_id + id_width_lp'(1);
      end else begin
        state_n = e_sched_idle;
      end
    end else if (send && link_ready_and_i) begin
      cnt_n = cnt_r + len_width_p'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_sched_idle;
      cnt_r      <= '0;
      len_r      <= '0;
      buf_r      <= '0;
      grant_id_r <= '0;
      rr_ptr_r   <= '0;
    end else begin
      state_r    <= state_n;
      cnt_r      <= cnt_n;
      len_r      <= len_n;
      buf_r      <= buf_n;
      grant_id_r <= grant_id_n;
      rr_ptr_r   <= rr_ptr_n;
    end
  end

  // A packet longer than the buffer would index past the captured flits.
  always @(posedge clk_i) begin
    if (reset_n_i && load && arb_v)
      assert (32'(win_len) < max_flits_p);
  end

endmodule

// File: doc/bp_me_wormhole_lce_cmd_flit_scheduler.md
Name: bp_me_wormhole_lce_cmd_flit_scheduler

Overview:
- Shares one coherence-network LCE command injection link among num_req_p requesters.
- Each requester presents a fully encoded wormhole packet: wormhole header, then message header, then optional data. It also presents the packet length in flits minus one, the same encoding as the wormhole len field.
- The block arbitrates round-robin, captures the winning packet into a single buffer and serializes it flit by flit onto a valid/ready link.
- Grant holds for the whole packet, so wormhole packets are never interleaved.
- Sits between the CCE/IO LCE-command sources and the coh NoC router injection port.

Parameters:
- num_req_p, 2, number of requesters; must be at least 1.
- flit_width_p, 64, coh NoC flit width in bits.
- len_width_p, 4, wormhole len field width.
- max_flits_p, 16, maximum flits per packet; must be at most 2^len_width_p.
- pkt_width_p, flit_width_p*max_flits_p, per-requester packet vector width; flit k occupies bits [k*flit_width_p +: flit_width_p].

Ports:
- clk_i  in  1  clock, rising edge.
- reset_n_i  in  1  asynchronous active-low reset.
- req_v_i  in  num_req_p  per-requester packet valid.
- req_pkt_i  in  num_req_p*pkt_width_p  per-requester packet; requester r at slice r.
- req_len_i  in  num_req_p*len_width_p  per-requester flit count minus 1.
- req_yumi_o  out  num_req_p  one-hot consume pulse; packet is dequeued in that cycle.
- link_data_o  out  flit_width_p  current flit.
- link_v_o  out  1  flit valid.
- link_ready_and_i  in  1  router accepts the flit when it is high together with link_v_o.
- busy_o  out  1  a packet is held in the buffer.
- grant_id_o  out  max(1,clog2(num_req_p))  requester owning the current packet; valid while busy_o.

Behaviour:
- Reset:
  - Asynchronous on reset_n_i low. State=IDLE, flit counter=0, rr_ptr=0, buffer cleared.
  - link_v_o=0, req_yumi_o=0, busy_o=0, grant_id_o=0. These take effect immediately, without waiting for a clock.
  - Reset asserted mid-packet abandons the packet with no further flits. The requester has already been yumi'd, so the packet is lost by design.
- Arbitration:
  - Combinational round-robin over req_v_i, starting at rr_ptr and searching upward with wrap.
  - It is evaluated only when the buffer can load ("load cycle").
  - A load cycle is either state IDLE, or state SEND while the last flit handshakes (link_v_o & link_ready_and_i & cnt==len).
- Load cycle with any req_v_i high:
  - req_yumi_o[winner]=1 in that cycle.
  - At the clock edge: buffer captures req_pkt_i/req_len_i of the winner, cnt<=0, grant_id_o<=winner, rr_ptr<=(winner+1) mod num_req_p, state<=SEND.
- Load cycle with no req_v_i: state<=IDLE and rr_ptr unchanged.
- req_yumi_o is zero in every other cycle. At most one bit is ever set.
- Latency: first flit appears on the link one cycle after the yumi cycle.
- Back-to-back packets run with zero bubbles: last flit of A and yumi of B fall in the same cycle, and B's flit 0 follows in the next cycle.
- SEND state:
  - link_v_o=1, busy_o=1, link_data_o=buffer flit[cnt].
  - Handshake with cnt<len: cnt<=cnt+1.
  - No handshake: all outputs stable.
  - link_data_o is registered/buffer-sourced, with no combinational path from req_pkt_i.
- IDLE state: link_v_o=0, busy_o=0, link_data_o=0.
- len=0: single-flit packet; its only handshake is the last-flit handshake.
- len≥max_flits_p: illegal. Assert in simulation; RTL behaviour is undefined.
- req_v_i may drop without yumi; requester is then skipped. Requesters must hold req_pkt_i/req_len_i stable while req_v_i is high.
- cnt width is len_width_p and compares against the buffered len. It never wraps because len<max_flits_p.

Decomposition:
- Shared package bp_me_wormhole_pkg holds:
  - the scheduler state enum (e_sched_idle, e_sched_send);
  - the flit-count helper constant function cdiv(bits, flit_width)-1 used by the encoders.
- One sub-module, bp_me_rr_arbiter: round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: grant one-hot, grant index, any-valid.
- The top holds the FSM, buffer, counter and rr_ptr register.

Test Plan:
- Single requester, len=2, link_ready_and_i=1: req_v[0] at cycle 0 -> yumi[0] at cycle 0; flits 0,1,2 of the packet on cycles 1-3; link_v_o=0 at cycle 4.
- Both requesters valid continuously, each len=1, rr_ptr=0 -> grant order 0,1,0,1. Flits are never interleaved within a packet. Yumi for the next packet coincides with each last flit, giving zero bubbles.
- Backpressure: len=3, link_ready_and_i toggles 1,0,0,1,1,0,1 -> link_data_o holds while ready is low; exactly 4 handshakes in order; yumi occurs once only.
- len=0 packets from requester 1 while requester 0 is idle -> one flit per packet on consecutive cycles; rr_ptr returns to 0 after each grant.
- Reset pulse (reset_n_i low, asynchronous, mid-cycle) during flit 2 of a len=5 packet -> link_v_o drops before the next edge. After release: busy_o=0, rr_ptr=0, and no residual flits.
- Requester drops req_v_i before winning -> never yumi'd; the other requester is served without delay.
